// File: rtl/oddeven_sort_engine.sv
// Frame-based odd-even transposition sorter.
// Loads up to NUM_DATA words over a valid/ready stream, sorts them in place,
// then streams the sorted words out with valid/ready/last.
module oddeven_sort_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DATA   = 8,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  descend,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int CW = $clog2(NUM_DATA + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_DATA - 1);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_SORT   = 2'd1;
  localparam logic [1:0] S_UNLOAD = 2'd2;

  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_n;
  logic [CW-1:0]         r_rd;
  logic [CW-1:0]         r_phase;
  logic                  r_desc;
  logic [DATA_WIDTH-1:0] r_buf     [NUM_DATA];
  logic [DATA_WIDTH-1:0] w_buf_nxt [NUM_DATA];

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_frame_end;
  logic                  w_desc_frame;
  logic                  w_rd_last;
  logic [DATA_WIDTH-1:0] w_pad_max;
  logic [DATA_WIDTH-1:0] w_pad_min;
  logic [DATA_WIDTH-1:0] w_pad;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // Magnitude compare honouring the SIGNED parameter.
  function automatic logic f_gt(input logic [DATA_WIDTH-1:0] a,
                                input logic [DATA_WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  assign in_ready   = (r_state == S_LOAD);
  assign out_valid  = (r_state == S_UNLOAD);
  assign busy       = (r_state == S_SORT) || (r_state == S_UNLOAD);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_frame_end = in_last || (r_cnt == LAST_IDX);
  assign w_rd_last  = (r_rd == r_n - CW'(1));
  assign out_last   = out_valid && w_rd_last;
  assign out_data   = out_valid ? w_rd_word : '0;

  // The first beat's descend applies to the whole frame, including its pads.
  assign w_desc_frame = (r_cnt == '0) ? descend : r_desc;

  // Pad value sorts to the tail: max for ascending, min for descending.
  always_comb begin
    w_pad_max = '1;
    w_pad_min = '0;
    if (SIGNED != 0) begin
      w_pad_max[DATA_WIDTH-1] = 1'b0;
      w_pad_min[DATA_WIDTH-1] = 1'b1;
    end
    w_pad = w_desc_frame ? w_pad_min : w_pad_max;
  end

  // Read mux for the unload pointer.
  always_comb begin
    w_rd_word = '0;
    for (int unsigned k = 0; k < NUM_DATA; k++) begin
      if (CW'(k) == r_rd) w_rd_word = r_buf[k];
    end
  end

  // Next buffer contents: load a beat (padding the tail on the final beat)
  // or run one compare-swap phase; pairs in a phase never overlap.
  always_comb begin
    w_buf_nxt = r_buf;
    if (w_in_fire) begin
      for (int unsigned k = 0; k < NUM_DATA; k++) begin
        if (CW'(k) == r_cnt) begin
          w_buf_nxt[k] = in_data;
        end else if (w_frame_end && (CW'(k) > r_cnt)) begin
          w_buf_nxt[k] = w_pad;
        end
      end
    end else if (r_state == S_SORT) begin
      for (int unsigned k = 0; k + 1 < NUM_DATA; k++) begin
        if (k[0] == r_phase[0]) begin
          if (r_desc ? f_gt(r_buf[k+1], r_buf[k]) : f_gt(r_buf[k], r_buf[k+1])) begin
            w_buf_nxt[k]   = r_buf[k+1];
            w_buf_nxt[k+1] = r_buf[k];
          end
        end
      end
    end
  end

  // Buffer storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_DATA; k++) r_buf[k] <= '0;
    end else begin
      r_buf <= w_buf_nxt;
    end
  end

  // Frame control: LOAD -> SORT -> UNLOAD -> LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_n     <= '0;
      r_rd    <= '0;
      r_phase <= '0;
      r_desc  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            if (r_cnt == '0) r_desc <= descend;
            if (w_frame_end) begin
              r_n     <= r_cnt + CW'(1);
              r_cnt   <= '0;
              r_phase <= '0;
              r_state <= S_SORT;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_SORT: begin
          if (r_phase == LAST_IDX) begin
            r_rd    <= '0;
            r_state <= S_UNLOAD;
          end else begin
            r_phase <= r_phase + CW'(1);
          end
        end
        S_UNLOAD: begin
          if (w_out_fire) begin
            if (w_rd_last) begin
              r_rd    <= '0;
              r_state <= S_LOAD;
            end else begin
              r_rd <= r_rd + CW'(1);
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: doc/oddeven_sort_engine.md
Name: oddeven_sort_engine

Overview:
- Parametrised, frame-based sorter: loads up to NUM_DATA words over a valid/ready stream, sorts them in place with odd-even transposition, then streams the result out with valid/ready/last.
- Successor to the single-mode bubble sorter: adds partial frames, ascending/descending mode, signed compare and back-pressure on both sides.
- Sits between a producer stream and a consumer stream in the algorithm datapath.
- Reusable back-to-back; one frame in flight.

Parameters:
- DATA_WIDTH, 16, element width in bits (>=1).
- NUM_DATA, 8, maximum elements per frame (>=2, any integer, not necessarily power of 2).
- SIGNED, 0, 1 = compare as two's complement; 0 = unsigned.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_WIDTH  input word.
- in_last  in  1  marks final word of a frame (may end frame early).
- descend  in  1  0 = ascending, 1 = descending; sampled on the first accepted beat of a frame.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts output.
- out_data  out  DATA_WIDTH  sorted word.
- out_last  out  1  marks final sorted word of the frame.
- busy  out  1  high in SORT or UNLOAD.

Behaviour:
- Reset: clk and rst as stated above (rst synchronous, active-high). Reset forces state LOAD, counts 0, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0. Reset mid-frame discards all buffered data; the next accepted beat starts a new frame.
- Handshake: a transfer occurs when valid&ready are high on a rising edge. out_data/out_last are held stable while out_valid=1 and out_ready=0.
- States: LOAD -> SORT -> UNLOAD -> LOAD.
- LOAD: in_ready=1.
  - Each accepted beat writes buf[cnt] and increments cnt.
  - The first beat of a frame latches descend.
  - On the accepted beat with in_last=1, or with cnt==NUM_DATA-1, n is latched as cnt+1 and the state moves to SORT.
  - Slots n..NUM_DATA-1 are filled with the pad value: max representable for ascending, min representable for descending (SIGNED-aware). Pads therefore sort to the tail.
  - Words beyond NUM_DATA cannot occur: the NUM_DATA-th beat ends the frame regardless of in_last.
- SORT: in_ready=0, busy=1. Exactly NUM_DATA cycles, phase counter p=0..NUM_DATA-1.
  - Even p: compare-swap pairs (0,1),(2,3),…
  - Odd p: compare-swap pairs (1,2),(3,4),…
  - All pairs in a phase are updated in parallel in one cycle.
  - Swap when buf[k]>buf[k+1] (ascending) or buf[k]<buf[k+1] (descending). Equal values are never swapped.
  - Odd NUM_DATA leaves one element unpaired per phase.
- UNLOAD: in_ready=0, busy=1, out_valid=1.
  - out_data=buf[rd]; out_last=(rd==n-1).
  - rd increments on each output transfer.
  - The transfer with out_last moves the state to LOAD, with in_ready=1 on the next cycle.
  - Pad slots are never output.
- Latency: if the last input transfer is at cycle T, SORT occupies T+1..T+NUM_DATA and out_valid first rises at T+NUM_DATA+1.
- n=1 (in_last on first beat): the full SORT still runs; a single word is output with out_last=1.
- Counters are sized $clog2(NUM_DATA+1). No wrap occurs within a frame.

Test Plan:
- NUM_DATA=8, DATA_WIDTH=8, ascending, inputs 5,3,8,1,9,2,7,4 with no back-pressure -> output 1,2,3,4,5,7,8,9; out_last on 9; first out_valid 9 cycles after the last input beat.
- Same data with descend=1, and descend toggled mid-frame after beat 0 -> output 9,8,7,5,4,3,2,1 (toggle ignored).
- Partial frame 200,10,10,0 with in_last on beat 4, ascending -> output 0,10,10,200, exactly 4 words, out_last on 200, no 255 pad emitted.
- SIGNED=1, inputs 0x7F,0x80,0xFF,0x01 (in_last) -> ascending output 0x80,0xFF,0x01,0x7F.
- Random out_ready (about 50% duty) over 3 back-to-back frames -> out_data held stable while stalled, no word lost or duplicated, in_ready=0 throughout SORT/UNLOAD.
- rst asserted for 1 cycle during SORT of frame 1, then frame 2 = 4,3,2,1 (in_last) -> only 1,2,3,4 emitted, no frame-1 residue.
